// File: rtl/sram_bank_sequencer.sv
// sram_bank_sequencer: initiator side of the sram_2port_bank access protocol.
// Takes one read/write request at a time on a valid/ready interface. It then walks the
// bank's control pins through the Bennett-clock phase boundaries, and returns one
// response per accepted request.
//
// Ports:
//   clk, reset            system clock, synchronous active-low reset
//   clkpos                Bennett phase levels, synchronous to clk
//   req_*                 request channel (valid/ready, write flag, addresses, write data)
//   rsp_*                 response channel (valid/ready, write echo, captured read data)
//   Addr_A, Addr_B,       bank address/data/enable pins
//   DataIn, ReadEn,
//   WriteEn, RegWrtBar
//   outA, outB            bank read data
module sram_bank_sequencer #(
  parameter int unsigned WIDTH   = 10,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned PH_ADDR = 2,
  parameter int unsigned PH_DATA = 4,
  parameter int unsigned PH_EN   = 6,
  parameter int unsigned PH_WEN  = 8,
  parameter int unsigned PH_WOFF = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  clkpos,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [ADDR_W-1:0] req_addr_b,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_data_a,
  output logic [DATA_W-1:0] rsp_data_b,
  output logic [ADDR_W-1:0] Addr_A,
  output logic [ADDR_W-1:0] Addr_B,
  output logic [DATA_W-1:0] DataIn,
  output logic              ReadEn,
  output logic              WriteEn,
  output logic              RegWrtBar,
  input  logic [DATA_W-1:0] outA,
  input  logic [DATA_W-1:0] outB
);

  typedef enum logic [2:0] {
    IDLE, WAIT_ADDR, WAIT_DATA, WAIT_EN, WAIT_WEN, WAIT_WOFF, WAIT_END, RESP
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  clkpos_d;
  logic [WIDTH-1:0]  rise;
  logic [WIDTH-1:0]  fall;
  logic              hold_write;
  logic [ADDR_W-1:0] hold_addr_a;
  logic [ADDR_W-1:0] hold_addr_b;
  logic [DATA_W-1:0] hold_wdata;

  // Phase edge detection against the previous clk sample.
  assign rise = clkpos & ~clkpos_d;
  assign fall = ~clkpos & clkpos_d;

  // Phases the protocol never consumes are folded here so they read as intentionally unused.
  logic unused_events;
  assign unused_events = ^{rise, fall};

  // Sequencer: each wait state consumes only its own phase event, so simultaneous
  // edges on other phases can never skip a step.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      clkpos_d    <= '0;
      hold_write  <= 1'b0;
      hold_addr_a <= '0;
      hold_addr_b <= '0;
      hold_wdata  <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_data_a  <= '0;
      rsp_data_b  <= '0;
      Addr_A      <= '0;
      Addr_B      <= '0;
      DataIn      <= '0;
      ReadEn      <= 1'b0;
      WriteEn     <= 1'b0;
      RegWrtBar   <= 1'b0;
    end else begin
      clkpos_d <= clkpos;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            hold_write  <= req_write;
            hold_addr_a <= req_addr_a;
            hold_addr_b <= req_addr_b;
            hold_wdata  <= req_wdata;
            req_ready   <= 1'b0;
            state       <= WAIT_ADDR;
          end
        end
        WAIT_ADDR: if (rise[PH_ADDR]) begin
          Addr_A <= hold_addr_a;
          Addr_B <= hold_addr_b;
          state  <= WAIT_DATA;
        end
        WAIT_DATA: if (rise[PH_DATA]) begin
          DataIn <= hold_write ? hold_wdata : '0;
          state  <= WAIT_EN;
        end
        WAIT_EN: if (rise[PH_EN]) begin
          if (hold_write) RegWrtBar <= 1'b1;
          else            ReadEn    <= 1'b1;
          state <= WAIT_WEN;
        end
        WAIT_WEN: if (rise[PH_WEN]) begin
          if (hold_write) begin
            WriteEn    <= 1'b1;
            rsp_data_a <= '0;
            rsp_data_b <= '0;
            state      <= WAIT_WOFF;
          end else begin
            // Bank outputs are still driven here because ReadEn drops at this same edge.
            ReadEn     <= 1'b0;
            rsp_data_a <= outA;
            rsp_data_b <= outB;
            state      <= WAIT_END;
          end
        end
        WAIT_WOFF: if (rise[PH_WOFF]) begin
          WriteEn <= 1'b0;
          state   <= WAIT_END;
        end
        WAIT_END: if (fall[PH_EN]) begin
          RegWrtBar <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_write <= hold_write;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bank_sequencer.sv
// tb_sram_bank_sequencer: drives a Bennett phase generator and a behavioural bank
// around sram_bank_sequencer, checking responses and pin timing against a reference model.
module tb_sram_bank_sequencer;

  localparam int unsigned WIDTH   = 10;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned PH_ADDR = 2;
  localparam int unsigned PH_DATA = 4;
  localparam int unsigned PH_EN   = 6;
  localparam int unsigned PH_WEN  = 8;
  localparam int unsigned PH_WOFF = 9;
  localparam int unsigned FRAME_STEPS = 2 * WIDTH;
  localparam int unsigned LIMIT = 4000;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [WIDTH-1:0]  clkpos;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr_a = '0;
  logic [ADDR_W-1:0] req_addr_b = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_data_a;
  logic [DATA_W-1:0] rsp_data_b;
  logic [ADDR_W-1:0] Addr_A;
  logic [ADDR_W-1:0] Addr_B;
  logic [DATA_W-1:0] DataIn;
  logic              ReadEn;
  logic              WriteEn;
  logic              RegWrtBar;
  logic [DATA_W-1:0] outA;
  logic [DATA_W-1:0] outB;

  always #5 clk = ~clk;

  sram_bank_sequencer #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PH_ADDR(PH_ADDR), .PH_DATA(PH_DATA),
    .PH_EN(PH_EN), .PH_WEN(PH_WEN), .PH_WOFF(PH_WOFF)
  ) dut (
    .clk(clk), .reset(reset), .clkpos(clkpos),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b),
    .Addr_A(Addr_A), .Addr_B(Addr_B), .DataIn(DataIn),
    .ReadEn(ReadEn), .WriteEn(WriteEn), .RegWrtBar(RegWrtBar),
    .outA(outA), .outB(outB)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural two-port bank: unwritten words return a per-address seed value.
  logic [DATA_W-1:0] seed [32];
  logic [DATA_W-1:0] bank [32];
  bit                written [32];
  assign outA = ReadEn ? (written[Addr_A] ? bank[Addr_A] : seed[Addr_A]) : '0;
  assign outB = ReadEn ? (written[Addr_B] ? bank[Addr_B] : seed[Addr_B]) : '0;
  always @(posedge clk) begin
    if (WriteEn && RegWrtBar) begin
      bank[Addr_A]    <= DataIn;
      written[Addr_A] <= 1'b1;
    end
  end

  // Bennett generator: phase k is high for steps k+1 .. 2*WIDTH-1-k of each frame.
  int unsigned step = 0;
  int unsigned dcnt = 0;
  int unsigned dwell = 1;
  int unsigned frame_id = 0;

  function automatic logic [WIDTH-1:0] phases_at(input int unsigned s);
    logic [WIDTH-1:0] p;
    p = '0;
    for (int k = 0; k < int'(WIDTH); k++)
      p[k] = (s >= 32'(k + 1)) && (s <= 32'(2 * int'(WIDTH) - 1 - k));
    return p;
  endfunction

  initial begin
    clkpos = '0;
    forever begin
      @(posedge clk); #2;
      if (dcnt + 1 >= dwell) begin
        dcnt = 0;
        if (step == FRAME_STEPS - 1) begin
          step = 0;
          frame_id++;
        end else begin
          step++;
        end
      end else begin
        dcnt++;
      end
      clkpos = phases_at(step);
    end
  end

  // Response-ready driver: 0 always ready, 1 stalled, 2 random.
  int unsigned rsp_mode = 0;
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #3;
      case (rsp_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'b0;
        default: rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Reference model: shadow memory plus an in-order queue of expected responses.
  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] aa;
    logic [ADDR_W-1:0] ab;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] ea;
    logic [DATA_W-1:0] eb;
    int unsigned       acc_frame;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] shadow [32];
  int unsigned       n_acc = 0;
  int unsigned       n_rsp = 0;
  int unsigned       n_drop = 0;
  int unsigned       n_unexp = 0;
  int unsigned       cyc = 0;
  int unsigned       last_acc_frame = 0;
  int unsigned       launch_frame = 0;
  int unsigned       launch_acc = 0;
  bit                rec_gaps = 1'b0;
  int unsigned       rsp_cyc_q[$];

  function automatic logic [63:0] all_outs();
    return {req_ready, rsp_valid, rsp_write, rsp_data_a, rsp_data_b,
            Addr_A, Addr_B, DataIn, ReadEn, WriteEn, RegWrtBar};
  endfunction

  // Monitor: samples 1 time unit after each edge; inputs are those the DUT just used.
  initial begin
    logic [WIDTH-1:0]  p_pos, ev_rise, ev_fall;
    logic              p_rr, p_rv, p_rw, p_re, p_we, p_rwb;
    logic [DATA_W-1:0] p_da, p_db, p_din;
    logic [ADDR_W-1:0] p_aa, p_ab;
    exp_t              e;
    p_pos = '0; p_rr = 0; p_rv = 0; p_rw = 0; p_re = 0; p_we = 0; p_rwb = 0;
    p_da = '0; p_db = '0; p_din = '0; p_aa = '0; p_ab = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      ev_rise = clkpos & ~p_pos;
      ev_fall = ~clkpos & p_pos;
      if (reset) begin
        if (p_rv && rsp_ready) begin
          n_rsp++;
          if (rec_gaps) rsp_cyc_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_unexp++;
          end else begin
            e = exp_q.pop_front();
            check_eq("rsp_payload", 64'({p_rw, p_da, p_db}), 64'({e.wr, e.ea, e.eb}));
          end
        end
        if (p_rr && req_valid) begin
          e.wr = req_write; e.aa = req_addr_a; e.ab = req_addr_b; e.wd = req_wdata;
          e.acc_frame = frame_id;
          if (req_write) begin
            e.ea = '0; e.eb = '0;
            shadow[req_addr_a] = req_wdata;
          end else begin
            e.ea = shadow[req_addr_a]; e.eb = shadow[req_addr_b];
          end
          exp_q.push_back(e);
          n_acc++;
          last_acc_frame = frame_id;
        end
        if (Addr_A != p_aa || Addr_B != p_ab) begin
          check_eq("addr_phase", 64'(ev_rise[PH_ADDR]), 64'(1));
          launch_frame = frame_id;
          launch_acc = last_acc_frame;
        end
        if (DataIn != p_din) check_eq("din_phase", 64'(ev_rise[PH_DATA]), 64'(1));
        if (RegWrtBar && !p_rwb) check_eq("rwb_on_phase", 64'(ev_rise[PH_EN]), 64'(1));
        if (!RegWrtBar && p_rwb) check_eq("rwb_off_phase", 64'(ev_fall[PH_EN]), 64'(1));
        if (ReadEn && !p_re) begin
          check_eq("ren_on_phase", 64'(ev_rise[PH_EN]), 64'(1));
          if (exp_q.size() != 0)
            check_eq("rd_bus", 64'({Addr_A, Addr_B, DataIn}),
                     64'({exp_q[0].aa, exp_q[0].ab, 16'h0}));
        end
        if (!ReadEn && p_re) check_eq("ren_off_phase", 64'(ev_rise[PH_WEN]), 64'(1));
        if (WriteEn && !p_we) begin
          check_eq("wen_on_phase", 64'(ev_rise[PH_WEN]), 64'(1));
          if (exp_q.size() != 0)
            check_eq("wr_bus", 64'({Addr_A, Addr_B, DataIn}),
                     64'({exp_q[0].aa, exp_q[0].ab, exp_q[0].wd}));
        end
        if (!WriteEn && p_we) check_eq("wen_off_phase", 64'(ev_rise[PH_WOFF]), 64'(1));
        if (rsp_valid && !p_rv) begin
          if (exp_q.size() == 0) n_unexp++;
          else check_eq("latency_frames", 64'((frame_id - exp_q[0].acc_frame) <= 2), 64'(1));
        end
      end
      if (WriteEn || ReadEn) check_eq("en_exclusive", 64'(WriteEn & ReadEn), 64'(0));
      if (WriteEn) check_eq("wen_under_rwb", 64'(RegWrtBar), 64'(1));
      p_pos = clkpos; p_rr = req_ready; p_rv = rsp_valid; p_rw = rsp_write;
      p_da = rsp_data_a; p_db = rsp_data_b; p_aa = Addr_A; p_ab = Addr_B; p_din = DataIn;
      p_re = ReadEn; p_we = WriteEn; p_rwb = RegWrtBar;
    end
  end

  // Present a request at a negedge and return at the negedge after it was accepted.
  task automatic send(input logic w, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                      input logic [DATA_W-1:0] d, input bit hold);
    int unsigned n;
    n = 0;
    req_valid = 1'b1; req_write = w; req_addr_a = a; req_addr_b = b; req_wdata = d;
    while (!req_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) begin
      check_eq("accept_timeout", 64'(n), 64'(0));
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) check_eq("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned       n;
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 32; i++) begin
      seed[i]   = DATA_W'($urandom);
      shadow[i] = seed[i];
    end

    // Power-on reset.
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("reset_outputs", all_outs(), 64'(0));
    end
    reset = 1'b1;
    @(negedge clk);
    check_eq("ready_after_reset", 64'(req_ready), 64'(1));

    // Directed write then read of the same word.
    send(1'b1, 5'd2, 5'd31, 16'hAAAA, 1'b0);
    wait_drain();
    check_eq("bank_word2", 64'(written[2] ? bank[2] : seed[2]), 64'(16'hAAAA));
    send(1'b0, 5'd2, 5'd0, 16'h0, 1'b0);
    wait_drain();

    // Late accept: request taken while phase PH_ADDR is already high.
    n = 0;
    while (!(req_ready && clkpos[PH_ADDR]) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    send(1'b0, 5'd17, 5'd5, 16'h0, 1'b0);
    wait_drain();
    check_eq("late_accept_frame", 64'(launch_frame - launch_acc), 64'(1));

    // Backpressure: response held for 50 clocks.
    rsp_mode = 1;
    @(negedge clk);
    send(1'b0, 5'd2, 5'd31, 16'h0, 1'b0);
    n = 0;
    while (!rsp_valid && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    repeat (50) begin
      @(negedge clk);
      if (exp_q.size() != 0)
        check_eq("bp_hold", 64'({rsp_valid, req_ready, rsp_write, rsp_data_a, rsp_data_b}),
                 64'({1'b1, 1'b0, 1'b0, exp_q[0].ea, exp_q[0].eb}));
    end
    rsp_mode = 0;
    wait_drain();

    // Reset while WriteEn is high: the op is dropped with no response.
    d = DATA_W'($urandom);
    send(1'b1, 5'd7, 5'd9, d, 1'b0);
    n = 0;
    while (!WriteEn && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("reached_write_enable", 64'(WriteEn), 64'(1));
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("mid_reset_outputs", all_outs(), 64'(0));
    end
    n_drop += exp_q.size();
    exp_q.delete();
    reset = 1'b1;
    @(negedge clk);
    send(1'b0, 5'd7, 5'd9, 16'h0, 1'b0);
    wait_drain();

    // Back-to-back: four writes then four reads with valid held, one op per frame.
    rec_gaps = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b1, ADDR_W'(8 + i), ADDR_W'(20 + i), DATA_W'($urandom), 1'b1);
    for (int i = 0; i < 4; i++) send(1'b0, ADDR_W'(8 + i), ADDR_W'(11 - i), 16'h0, (i != 3));
    req_valid = 1'b0;
    wait_drain();
    rec_gaps = 1'b0;
    check_eq("b2b_rsp_count", 64'(rsp_cyc_q.size()), 64'(8));
    for (int i = 1; i < rsp_cyc_q.size(); i++)
      check_eq("b2b_gap", 64'(rsp_cyc_q[i] - rsp_cyc_q[i - 1]), 64'(FRAME_STEPS));

    // Randomized traffic with random phase dwell and response backpressure.
    rsp_mode = 2;
    for (int i = 0; i < 40; i++) begin
      if (i % 10 == 0) begin
        wait_drain();
        dwell = $urandom_range(1, 3);
      end
      repeat ($urandom_range(0, 8)) @(negedge clk);
      send(1'($urandom), ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)),
           DATA_W'($urandom), 1'b0);
    end
    wait_drain();
    rsp_mode = 0;
    repeat (5) @(negedge clk);

    check_eq("response_count", 64'(n_rsp), 64'(n_acc - n_drop));
    check_eq("unexpected_responses", 64'(n_unexp), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
